// File: rtl/temp_poll_monitor.sv
// temp_poll_monitor: periodically requests a TMP75 conversion, captures the
// signed 12-bit result and derives current, smoothed (EMA) and peak
// temperature, a hysteretic over-temp alarm and a sticky no-response flag.
module temp_poll_monitor #(
    parameter logic [31:0]        POLL_CYCLES    = 32'd10_000_000,
    parameter logic [31:0]        TIMEOUT_CYCLES = 32'd20_000,
    parameter int                 AVG_LOG2       = 3,
    parameter logic signed [11:0] ALARM_HI       = 12'sd1280,
    parameter logic signed [11:0] ALARM_LO       = 12'sd1200
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               clr_max,
    input  logic               clr_err,
    output logic               temp_rd_en,
    input  logic signed [11:0] temp_data_in,
    input  logic               temp_data_en_in,
    output logic signed [11:0] temp_cur,
    output logic signed [11:0] temp_avg,
    output logic signed [11:0] temp_max,
    output logic               temp_valid,
    output logic               over_temp,
    output logic               timeout_err,
    output logic [15:0]        sample_cnt,
    output logic               busy
);
    localparam int ACC_W = 12 + AVG_LOG2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_DATA,
        S_UPDATE,
        S_ALARM,
        S_WAIT_POLL
    } state_e;

    state_e                  state_q, state_d;
    logic                    req_lvl_q, req_lvl_d;
    logic [31:0]             poll_cnt_q, poll_cnt_d;
    logic [31:0]             to_cnt_q, to_cnt_d;
    logic signed [11:0]      sample_q, sample_d;
    logic signed [11:0]      temp_cur_q, temp_cur_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [11:0]      temp_max_q, temp_max_d;
    logic                    max_valid_q, max_valid_d;
    logic                    first_flag_q, first_flag_d;
    logic                    temp_valid_q, temp_valid_d;
    logic                    over_temp_q, over_temp_d;
    logic                    timeout_err_q, timeout_err_d;
    logic [15:0]             sample_cnt_q, sample_cnt_d;

    logic signed [ACC_W-1:0] sample_ext;
    logic signed [11:0]      avg;

    // Sign-extended captured sample and the EMA output taken from the accumulator.
    assign sample_ext = ACC_W'(sample_q);
    assign avg        = 12'(acc_q >>> AVG_LOG2);

    // Request is masked during the strobe so the reader never re-triggers on a stale level.
    assign temp_rd_en  = req_lvl_q & ~temp_data_en_in;
    assign temp_cur    = temp_cur_q;
    assign temp_avg    = avg;
    assign temp_max    = temp_max_q;
    assign temp_valid  = temp_valid_q;
    assign over_temp   = over_temp_q;
    assign timeout_err = timeout_err_q;
    assign sample_cnt  = sample_cnt_q;
    assign busy        = (state_q == S_REQ) || (state_q == S_WAIT_DATA);

    // Next-state and datapath: poll/timeout counting, capture, EMA, peak, alarm.
    always_comb begin
        // NOTE: every _d defaults to its _q first so no path can infer a latch.
        state_d       = state_q;
        req_lvl_d     = req_lvl_q;
        poll_cnt_d    = poll_cnt_q;
        to_cnt_d      = to_cnt_q;
        sample_d      = sample_q;
        temp_cur_d    = temp_cur_q;
        acc_d         = acc_q;
        temp_max_d    = temp_max_q;
        max_valid_d   = max_valid_q;
        first_flag_d  = first_flag_q;
        temp_valid_d  = 1'b0;
        over_temp_d   = over_temp_q;
        timeout_err_d = timeout_err_q;
        sample_cnt_d  = sample_cnt_q;

        // Period counter runs outside IDLE and saturates one below the period.
        if (state_q != S_IDLE && poll_cnt_q < POLL_CYCLES - 32'd1) begin
            poll_cnt_d = poll_cnt_q + 32'd1;
        end

        // Clear first so a timeout in the same cycle wins.
        if (clr_err) begin
            timeout_err_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                req_lvl_d  = 1'b1;
                poll_cnt_d = 32'd0;
                to_cnt_d   = 32'd0;
                state_d    = S_WAIT_DATA;
            end
            S_WAIT_DATA: begin
                to_cnt_d = to_cnt_q + 32'd1;
                if (temp_data_en_in) begin
                    sample_d  = temp_data_in;
                    req_lvl_d = 1'b0;
                    state_d   = S_UPDATE;
                end else if (to_cnt_q == TIMEOUT_CYCLES - 32'd1) begin
                    timeout_err_d = 1'b1;
                    req_lvl_d     = 1'b0;
                    state_d       = S_WAIT_POLL;
                end
            end
            S_UPDATE: begin
                temp_cur_d   = sample_q;
                sample_cnt_d = sample_cnt_q + 16'd1;
                if (first_flag_q) begin
                    acc_d        = sample_ext <<< AVG_LOG2;
                    first_flag_d = 1'b0;
                end else begin
                    acc_d = acc_q + sample_ext - (acc_q >>> AVG_LOG2);
                end
                if (!max_valid_q || sample_q > temp_max_q) begin
                    temp_max_d = sample_q;
                end
                max_valid_d = 1'b1;
                state_d     = S_ALARM;
            end
            S_ALARM: begin
                if (avg >= ALARM_HI) begin
                    over_temp_d = 1'b1;
                end else if (avg <= ALARM_LO) begin
                    over_temp_d = 1'b0;
                end
                temp_valid_d = 1'b1;
                state_d      = S_WAIT_POLL;
            end
            S_WAIT_POLL: begin
                // Compare the count including this cycle so REQ entries are exactly one period apart.
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (poll_cnt_d >= POLL_CYCLES - 32'd1) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Peak reload request lands after the update so the next sample reloads temp_max.
        if (clr_max) begin
            max_valid_d = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values together.
        if (rst) begin
            state_q       <= S_IDLE;
            req_lvl_q     <= 1'b0;
            poll_cnt_q    <= 32'd0;
            to_cnt_q      <= 32'd0;
            sample_q      <= '0;
            temp_cur_q    <= '0;
            acc_q         <= '0;
            temp_max_q    <= '0;
            max_valid_q   <= 1'b0;
            first_flag_q  <= 1'b1;
            temp_valid_q  <= 1'b0;
            over_temp_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            sample_cnt_q  <= 16'd0;
        end else begin
            state_q       <= state_d;
            req_lvl_q     <= req_lvl_d;
            poll_cnt_q    <= poll_cnt_d;
            to_cnt_q      <= to_cnt_d;
            sample_q      <= sample_d;
            temp_cur_q    <= temp_cur_d;
            acc_q         <= acc_d;
            temp_max_q    <= temp_max_d;
            max_valid_q   <= max_valid_d;
            first_flag_q  <= first_flag_d;
            temp_valid_q  <= temp_valid_d;
            over_temp_q   <= over_temp_d;
            timeout_err_q <= timeout_err_d;
            sample_cnt_q  <= sample_cnt_d;
        end
    end

endmodule
